// File: rtl/wb_eq_multiband.sv
// wb_eq_multiband: multi-band FIR equaliser built around one time-multiplexed
// MAC. Coefficients, per-band gain/enable and bypass are set over Wishbone
// classic; the summed result is saturated to OW bits.
module wb_eq_multiband #(
  parameter int DW    = 8,
  parameter int TAPS  = 16,
  parameter int BANDS = 2,
  parameter int CW    = 10,
  parameter int GW    = 3,
  parameter int OW    = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] datain,
  input  logic          RDYin,
  output logic [OW-1:0] dataout,
  output logic          RDYout,
  input  logic          wb_stb_i,
  input  logic          wb_cyc_i,
  input  logic          wb_we_i,
  input  logic [31:0]   wb_adr_i,
  input  logic [3:0]    wb_sel_i,
  input  logic [31:0]   wb_dat_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o
);

  localparam int TIW       = $clog2(TAPS);
  localparam int BIW       = (BANDS > 1) ? $clog2(BANDS) : 1;
  localparam int NCOEF     = BANDS * TAPS;
  localparam int CIW       = $clog2(NCOEF);
  localparam int AW        = DW + CW + TIW;
  // Wide enough that the largest shifted band sum of all bands never wraps.
  // The clamp below assumes TW > OW, which holds for any sensible parameter set.
  localparam int TW        = AW + (2**GW - 1) + $clog2(BANDS) + 1;
  localparam int GAIN_WORD = 2;   // 0x008
  localparam int COEF_WORD = 64;  // 0x100

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_SAT, S_OUT} state_t;

  state_t state, state_nxt;

  // Sample path
  logic signed [DW-1:0] x_line [TAPS];
  logic [TIW-1:0]       tap_idx;
  logic [BIW-1:0]       band_idx;
  logic [CIW-1:0]       coef_idx;
  logic signed [AW-1:0] acc, acc_sum;
  logic signed [TW-1:0] total, band_ext, shifted;
  logic signed [DW+CW-1:0] prod;
  logic [CW-1:0]        coef_cur;
  logic [DW-1:0]        x_cur;
  logic [OW-1:0]        sat_val;
  logic                 last_tap, last_band, fits;
  logic [GW-1:0]        gain_snap [BANDS];
  logic [BANDS-1:0]     en_snap;
  logic                 bypass_snap;

  // Register file and bus
  logic signed [CW-1:0] coef_mem [NCOEF];
  logic [GW-1:0]        gain_reg [BANDS];
  logic [BANDS-1:0]     en_reg;
  logic                 bypass, overrun, overrun_set, busy;
  logic                 ack_q, wb_go;
  logic [9:0]           word;
  logic                 aligned, hit_ctrl, hit_status, hit_gain, hit_coef;
  logic [BIW-1:0]       gain_sel;
  logic [CIW-1:0]       coef_sel;
  logic [31:0]          rd_data;
  logic                 unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:12], wb_dat_i};

  assign busy        = (state != S_IDLE);
  assign overrun_set = RDYin && busy;
  assign last_tap    = (tap_idx == TIW'(TAPS - 1));
  assign last_band   = (band_idx == BIW'(BANDS - 1));

  // One product per MAC cycle; the coefficient is read live from the register file.
  // The true product fits DW+CW signed bits, so the low bits of the extended
  // operands' product are exact.
  assign coef_cur = coef_mem[coef_idx];
  assign x_cur    = x_line[tap_idx];
  assign prod     = $signed({{DW{coef_cur[CW-1]}}, coef_cur} * {{CW{x_cur[DW-1]}}, x_cur});
  assign acc_sum  = acc + {{TIW{prod[DW+CW-1]}}, prod};
  assign band_ext = {{(TW-AW){acc_sum[AW-1]}}, acc_sum};
  assign shifted  = band_ext <<< gain_snap[band_idx];
  assign fits     = (&total[TW-1:OW-1]) || ~(|total[TW-1:OW-1]);

  // Next-state logic of the sample sequencer.
  always_comb begin
    // NOTE: assigning a default before the case guarantees no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (RDYin) state_nxt = S_MAC;
      S_MAC:   if (last_tap && last_band) state_nxt = S_SAT;
      S_SAT:   state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output value: sign-extended newest sample in bypass, otherwise the clamped total.
  always_comb begin
    sat_val = total[OW-1:0];
    if (bypass_snap)   sat_val = {{(OW-DW){x_line[0][DW-1]}}, x_line[0]};
    else if (!fits)    sat_val = total[TW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
  end

  // Sequencer state, delay line, accumulators and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      for (int i = 0; i < TAPS; i++) x_line[i] <= '0;
      for (int b = 0; b < BANDS; b++) gain_snap[b] <= '0;
      en_snap     <= '0;
      bypass_snap <= 1'b1;
      tap_idx     <= '0;
      band_idx    <= '0;
      coef_idx    <= '0;
      acc         <= '0;
      total       <= '0;
      dataout     <= '0;
      RDYout      <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      state  <= state_nxt;
      RDYout <= 1'b0;
      unique case (state)
        S_IDLE: if (RDYin) begin
          for (int i = TAPS - 1; i > 0; i--) x_line[i] <= x_line[i-1];
          x_line[0]   <= datain;
          gain_snap   <= gain_reg;
          en_snap     <= en_reg;
          bypass_snap <= bypass;
          tap_idx     <= '0;
          band_idx    <= '0;
          coef_idx    <= '0;
          acc         <= '0;
          total       <= '0;
        end
        S_MAC: begin
          coef_idx <= coef_idx + CIW'(1);
          if (last_tap) begin
            if (en_snap[band_idx]) total <= total + shifted;
            acc      <= '0;
            tap_idx  <= '0;
            band_idx <= band_idx + BIW'(1);
          end else begin
            acc     <= acc_sum;
            tap_idx <= tap_idx + TIW'(1);
          end
        end
        S_SAT: begin
          dataout <= sat_val;
          RDYout  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Wishbone address decode (byte address, only [11:0] significant).
  assign word       = wb_adr_i[11:2];
  assign aligned    = (wb_adr_i[1:0] == 2'b00);
  assign hit_ctrl   = aligned && (word == 10'd0);
  assign hit_status = aligned && (word == 10'd1);
  assign hit_gain   = aligned && (int'(word) >= GAIN_WORD) && (int'(word) < GAIN_WORD + BANDS);
  assign hit_coef   = aligned && (int'(word) >= COEF_WORD) && (int'(word) < COEF_WORD + NCOEF);
  assign gain_sel   = BIW'(int'(word) - GAIN_WORD);
  assign coef_sel   = CIW'(int'(word) - COEF_WORD);
  assign wb_go      = wb_stb_i && wb_cyc_i && !ack_q;
  assign wb_ack_o   = wb_stb_i && wb_cyc_i && ack_q;

  // Read data mux; unmapped locations read 0xFF.
  always_comb begin
    rd_data = 32'h0000_00FF;
    if (hit_ctrl) begin
      rd_data = {31'd0, bypass};
    end else if (hit_status) begin
      rd_data = {30'd0, overrun, busy};
    end else if (hit_gain) begin
      rd_data            = '0;
      rd_data[GW-1:0]    = gain_reg[gain_sel];
      rd_data[8]         = en_reg[gain_sel];
    end else if (hit_coef) begin
      rd_data = {{(32-CW){coef_mem[coef_sel][CW-1]}}, coef_mem[coef_sel]};
    end
  end

  // Register file writes, registered read data, ack and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q    <= 1'b0;
      wb_dat_o <= '0;
      bypass   <= 1'b1;
      overrun  <= 1'b0;
      en_reg   <= '0;
      for (int b = 0; b < BANDS; b++) gain_reg[b] <= '0;
      // NOTE: the coefficient array is reset deliberately because software
      // relies on a defined all-zero filter after reset.
      for (int i = 0; i < NCOEF; i++) coef_mem[i] <= '0;
    end else begin
      ack_q <= wb_stb_i && wb_cyc_i && !ack_q;
      if (wb_go && !wb_we_i) wb_dat_o <= rd_data;
      if (wb_go && wb_we_i) begin
        if (hit_ctrl) begin
          bypass <= wb_dat_i[0];
          if (wb_dat_i[1]) overrun <= 1'b0;
        end
        if (hit_gain) begin
          gain_reg[gain_sel] <= wb_dat_i[GW-1:0];
          en_reg[gain_sel]   <= wb_dat_i[8];
        end
        if (hit_coef) coef_mem[coef_sel] <= wb_dat_i[CW-1:0];
      end
      // A new overrun in the same cycle as a clear wins.
      if (overrun_set) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_eq_multiband.sv
// Self-checking bench for wb_eq_multiband: directed scenarios plus randomized
// coefficient/gain/sample sets compared against an arithmetic reference model.
module tb_wb_eq_multiband;

  localparam int DW = 8, TAPS = 16, BANDS = 2, CW = 10, GW = 3, OW = 24;
  localparam int L  = BANDS * TAPS + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] datain = '0;
  logic          RDYin = 1'b0;
  logic [OW-1:0] dataout;
  logic          RDYout;
  logic          wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0]   wb_adr_i = '0;
  logic [3:0]    wb_sel_i = 4'hF;
  logic [31:0]   wb_dat_i = '0;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;

  always #5 clk = ~clk;

  wb_eq_multiband #(.DW(DW), .TAPS(TAPS), .BANDS(BANDS), .CW(CW), .GW(GW), .OW(OW)) dut (
    .clk(clk), .reset(reset), .datain(datain), .RDYin(RDYin),
    .dataout(dataout), .RDYout(RDYout),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Reference model state
  int m_coef [BANDS][TAPS];
  int m_x    [TAPS];
  int m_gain [BANDS];
  bit m_en   [BANDS];
  bit m_bypass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < BANDS; b++) begin
      m_gain[b] = 0;
      m_en[b]   = 1'b0;
      for (int t = 0; t < TAPS; t++) m_coef[b][t] = 0;
    end
    for (int t = 0; t < TAPS; t++) m_x[t] = 0;
    m_bypass = 1'b1;
  endtask

  function automatic logic [OW-1:0] model_expect();
    longint tot = 0;
    longint s;
    longint lim = longint'(1) << (OW - 1);
    if (m_bypass) return OW'(m_x[0]);
    for (int b = 0; b < BANDS; b++) begin
      s = 0;
      for (int t = 0; t < TAPS; t++) s += longint'(m_coef[b][t]) * longint'(m_x[t]);
      if (m_en[b]) tot += s * (longint'(1) << m_gain[b]);
    end
    if (tot > lim - 1) tot = lim - 1;
    else if (tot < -lim) tot = -lim;
    return OW'(tot);
  endfunction

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // One Wishbone classic access; checks the single wait state before ack.
  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
    int waits = 0;
    bit got = 1'b0;
    @(posedge clk); #1;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wdat;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (wb_ack_o) got = 1'b1;
      else waits++;
    end
    rdat = wb_dat_o;
    check("wb_ack_wait", 64'(waits), 64'd1);
    @(posedge clk); #1;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    wb_access(1'b1, adr, d, dummy);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] d);
    wb_access(1'b0, adr, 32'h0, d);
  endtask

  task automatic set_coef(input int b, input int t, input int v);
    wb_write(32'h100 + 32'(4 * (b * TAPS + t)), 32'(v));
    m_coef[b][t] = v;
  endtask

  task automatic set_gain(input int b, input bit en, input int g);
    wb_write(32'h8 + 32'(4 * b), (en ? 32'h100 : 32'h0) | 32'(g));
    m_en[b]   = en;
    m_gain[b] = g;
  endtask

  task automatic set_ctrl(input logic [31:0] v);
    wb_write(32'h0, v);
    m_bypass = v[0];
  endtask

  // Feed one sample in IDLE and check latency, value and pulse width.
  task automatic send_sample(input logic [DW-1:0] d, input string tag);
    logic [OW-1:0] exp;
    int lat = 0;
    bit seen = 1'b0;
    for (int i = TAPS - 1; i > 0; i--) m_x[i] = m_x[i-1];
    m_x[0] = int'($signed(d));
    exp = model_expect();
    @(posedge clk); #1 RDYin = 1'b1; datain = d;
    @(posedge clk); #1 RDYin = 1'b0;
    while (!seen && lat < 3 * L) begin
      @(negedge clk);
      lat++;
      if (RDYout) seen = 1'b1;
    end
    check({tag, "_lat"}, 64'(lat), 64'(L));
    check({tag, "_data"}, 64'(dataout), 64'(exp));
    @(negedge clk);
    check({tag, "_pulse"}, 64'(RDYout), 64'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int pulses, first_lat;
    logic [OW-1:0] exp, got_out;

    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_dataout", 64'(dataout), 64'd0);
    check("rst_rdyout", 64'(RDYout), 64'd0);
    check("rst_dat_o", 64'(wb_dat_o), 64'd0);
    check("rst_ack", 64'(wb_ack_o), 64'd0);
    wb_read(32'h0, rd);  check("rst_ctrl", 64'(rd), 64'd1);
    wb_read(32'h4, rd);  check("rst_status", 64'(rd), 64'd0);

    // Bypass after reset
    send_sample(8'h85, "bypass");
    check("bypass_const", 64'(dataout), 64'hFFFF85);

    // Impulse response of band 0
    do_reset();
    set_ctrl(32'h0);
    for (int t = 0; t < TAPS; t++) set_coef(0, t, t + 1);
    set_gain(0, 1'b1, 0);
    for (int k = 0; k < TAPS; k++) begin
      send_sample((k == 0) ? 8'h40 : 8'h00, "impulse");
      check("impulse_const", 64'(dataout), 64'(64 * (k + 1)));
    end

    // Two-band gain on a fresh delay line
    do_reset();
    set_ctrl(32'h0);
    for (int t = 0; t < TAPS; t++) set_coef(0, t, t + 1);
    set_gain(0, 1'b1, 0);
    set_coef(1, 0, -512);
    set_gain(1, 1'b1, 3);
    send_sample(8'd127, "twoband");
    check("twoband_const", 64'(dataout), 64'hF8107F);

    // Saturation, positive then negative
    for (int t = 0; t < TAPS; t++) set_coef(0, t, 511);
    set_gain(0, 1'b1, 7);
    set_gain(1, 1'b0, 0);
    for (int k = 0; k < TAPS; k++) send_sample(8'd127, "satpos");
    check("satpos_const", 64'(dataout), 64'h7FFFFF);
    for (int k = 0; k < TAPS; k++) send_sample(8'h80, "satneg");
    check("satneg_const", 64'(dataout), 64'h800000);

    // Randomized configurations and samples
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < BANDS; b++)
        for (int t = 0; t < TAPS; t++)
          set_coef(b, t, int'($urandom_range(0, 1023)) - 512);
      for (int b = 0; b < BANDS; b++)
        set_gain(b, 1'($urandom_range(0, 1)), int'($urandom_range(0, (r < 2) ? 1 : 7)));
      set_ctrl(($urandom_range(0, 3) == 0) ? 32'h1 : 32'h0);
      for (int s = 0; s < 6; s++) send_sample(8'($urandom), "rand");
    end

    // Overrun: second strobe 10 cycles after the first is dropped
    set_ctrl(32'h0);
    for (int i = TAPS - 1; i > 0; i--) m_x[i] = m_x[i-1];
    m_x[0] = 37;
    exp = model_expect();
    @(posedge clk); #1 RDYin = 1'b1; datain = 8'd37;
    @(posedge clk); #1 RDYin = 1'b0;
    repeat (9) @(posedge clk);
    #1 RDYin = 1'b1; datain = 8'd99;
    @(posedge clk); #1 RDYin = 1'b0;
    pulses = 0; first_lat = 0; got_out = '0;
    for (int i = 11; i <= 11 + 2 * L; i++) begin
      @(negedge clk);
      if (RDYout) begin
        pulses++;
        if (pulses == 1) begin first_lat = i; got_out = dataout; end
      end
    end
    check("ovr_pulses", 64'(pulses), 64'd1);
    check("ovr_lat", 64'(first_lat), 64'(L));
    check("ovr_data", 64'(got_out), 64'(exp));
    wb_read(32'h4, rd);  check("ovr_status", 64'(rd), 64'h2);
    set_ctrl(32'h2);
    wb_read(32'h4, rd);  check("ovr_cleared", 64'(rd), 64'h0);
    wb_read(32'h0, rd);  check("ovr_ctrl", 64'(rd), 64'h0);
    send_sample(8'hC3, "after_ovr");

    // Wishbone map details
    wb_read(32'h0FC, rd);  check("unmapped_rd", 64'(rd), 64'hFF);
    wb_read(32'h010, rd);  check("unmapped_gain", 64'(rd), 64'hFF);
    wb_write(32'h17C, 32'h3FF);
    m_coef[1][15] = -1;
    wb_read(32'h17C, rd);  check("coef_signext", 64'(rd), 64'hFFFFFFFF);
    set_gain(1, 1'b1, 5);
    wb_read(32'h00C, rd);  check("gain_rd", 64'(rd), 64'h105);
    wb_write(32'h4, 32'hFFFFFFFF);
    wb_read(32'h4, rd);    check("status_ro", 64'(rd), 64'h0);

    // Reset during a computation discards the result
    @(posedge clk); #1 RDYin = 1'b1; datain = 8'h55;
    @(posedge clk); #1 RDYin = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    pulses = 0;
    for (int i = 0; i < 2 * L; i++) begin
      @(negedge clk);
      if (RDYout) pulses++;
    end
    check("midrst_pulses", 64'(pulses), 64'd0);
    check("midrst_dataout", 64'(dataout), 64'd0);
    wb_read(32'h4, rd);    check("midrst_status", 64'(rd), 64'h0);
    wb_read(32'h0, rd);    check("midrst_ctrl", 64'(rd), 64'h1);
    wb_read(32'h17C, rd);  check("midrst_coef", 64'(rd), 64'h0);
    send_sample(8'h7F, "post_rst");

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/wb_eq_multiband.md
# wb_eq_multiband

Parametrised, Wishbone-controlled multi-band FIR equaliser for the effects-pedal audio path. It replaces the fixed two-band bass/high equaliser with one time-multiplexed MAC engine. Coefficients for `BANDS` bands of `TAPS` taps each are runtime-loadable over Wishbone. Each band has its own gain shift and enable, the summed result saturates to the output width, and the block adds bypass and overrun detection. It sits between the ADC sample interface (`datain`/`RDYin`) and the output mixer stage (`dataout`/`RDYout`).

## Interface
- `DW`, 8 — input sample width, signed two's complement.
- `TAPS`, 16 — taps per band, ≥2.
- `BANDS`, 2 — number of bands, 1..8.
- `CW`, 10 — coefficient width, signed.
- `GW`, 3 — gain field width; gain is a left shift of 0..2^GW−1.
- `OW`, 24 — output width, signed, saturated.
- `clk` in 1 — single clock; all logic on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `datain` in DW — input sample.
- `RDYin` in 1 — one-cycle strobe; `datain` is valid in the same cycle.
- `dataout` out OW — equalised sample.
- `RDYout` out 1 — one-cycle strobe; `dataout` is valid in the same cycle and held until the next strobe.
- `wb_stb_i`, `wb_cyc_i`, `wb_we_i` in 1 — Wishbone classic strobe, cycle and write enable.
- `wb_adr_i` in 32 — byte address; only [11:0] is decoded.
- `wb_sel_i` in 4 — ignored; all accesses are full-word.
- `wb_dat_i` in 32 — write data.
- `wb_dat_o` out 32 — read data, registered.
- `wb_ack_o` out 1 — acknowledge.

## Operation
- **Delay line:** `TAPS` × DW registers x[0..TAPS−1]. An accepted sample shifts into x[0], and x[TAPS−1] is discarded. Reset clears the line to 0.
- **FSM states:**
  - IDLE: `RDYin`=1 → capture sample, snapshot gain/enable/bypass, clear accumulators, go to MAC.
  - MAC: one product coef[b][t]·x[t] per cycle, visited in order b=0..BANDS−1, t=0..TAPS−1. At the last tap of band b, add (acc_b <<< gain_b) to the total if band b is enabled, then clear acc_b. After the final band, go to SAT.
  - SAT: clamp the total to [−2^(OW−1), 2^(OW−1)−1]. If bypass is set, use sign-extended x[0] instead. Go to OUT.
  - OUT: drive `dataout` and `RDYout`=1, return to IDLE.
- **Widths:**
  - acc: DW+CW+clog2(TAPS).
  - Total: acc width + 2^GW−1 + clog2(BANDS) + 1. No intermediate overflow is permitted.
- **Overrun:** `RDYin` outside IDLE is dropped (no shift, no restart) and sets sticky STATUS.overrun.
- **Coefficient writes while busy:** take effect immediately (the MAC reads live). Gain, enable and bypass are snapshotted in IDLE.
- **Register map:**
  - 0x000 CTRL, RW: bit0 bypass, reset value 1. Bit1 is write-1-to-clear overrun and reads 0.
  - 0x004 STATUS, RO: bit0 busy (FSM≠IDLE), bit1 overrun.
  - 0x008+4b GAIN[b], RW: [GW−1:0] gain, bit8 enable. Reset value 0.
  - 0x100+4(b·TAPS+t) COEF[b][t], RW: signed CW bits; reads are sign-extended to 32 bits. Reset value 0.
  - Unmapped: reads return 0x000000FF; writes are ignored. Writes to STATUS are ignored.
- **Wishbone access:**
  - Access executes in the cycle where stb&cyc&~ack; ack is registered as ack ← stb&cyc&~ack.
  - `wb_ack_o` = stb&cyc&ack, giving exactly one ack per access with one wait state.
  - `wb_dat_o` updates only on reads.
- **Reset, including mid-operation:** FSM→IDLE, all registers at reset values, `dataout`=0, `RDYout`=0, `wb_dat_o`=0, ack=0. Any in-flight result is discarded and no `RDYout` follows.

## Timing
- L = BANDS·TAPS + 2 = 34 cycles by default.
- `RDYin` sampled high in IDLE at edge T → `RDYout` high in cycle T+L, for exactly one cycle.
- Bypass does not change latency.
- The next sample is accepted at the earliest in the cycle after `RDYout`.
- Maximum sustained input rate is one sample per L+1 cycles.
- A `RDYin` arriving in the same cycle as `RDYout` is an overrun.

## Test plan
Defaults unless stated; L=34.
- **Reset/bypass:** reset, then `RDYin` with `datain`=0x85 → `RDYout` at T+34, `dataout`=0xFFFF85.
- **Impulse response:** bypass=0, COEF[0][t]=t+1, GAIN[0]=0x100. Feed 0x40 then 15 zeros → outputs 64, 128, …, 1024.
- **Two-band gain:** add COEF[1][0]=−512, GAIN[1]=0x103, fresh delay line. Feed 127 → `dataout`=0xF8107F (127 − 520192).
- **Saturation:** COEF[0][*]=511, GAIN[0]=0x107, band 1 disabled.
  - 16 samples of 127 → 16th output 0x7FFFFF.
  - Then 16 samples of −128 → 16th output 0x800000.
- **Overrun:** second `RDYin` 10 cycles after the first → exactly one `RDYout`, delay line shifted once, STATUS reads 0x2. Write CTRL=0x2 → STATUS reads 0x0, bypass=0.
- **Wishbone and reset:**
  - Read 0x0FC → 0xFF.
  - Write COEF[1][15]=0x3FF → reads 0xFFFFFFFF.
  - Each access acks exactly one cycle.
  - Assert reset at T+10 → no `RDYout`, STATUS=0, CTRL=0x1.
